// File: rtl/joystick_conditioner.sv
// Purpose: synchronise, debounce and edge-detect five active-low joystick pins; optional auto-repeat (JOYSTICK_AUTOREPEAT_EN).
// Latency: 2 sync cycles + wait for the DEBOUNCE_TICKS-th tick of continuous mismatch + 1 register cycle.
// Backpressure: none; free-running, outputs are levels and single-cycle pulses.
module joystick_conditioner #(
    parameter int TICK_DIV           = 50000,
    parameter int DEBOUNCE_TICKS     = 5,
    parameter int REPEAT_DELAY_TICKS = 400,
    parameter int REPEAT_RATE_TICKS  = 100
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [4:0] joy_raw_n,
    output logic [4:0] joy_level,
    output logic [4:0] joy_press
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_TICKS - 1);

    logic [4:0]          sync1_q;
    logic [4:0]          sync2_q;
    logic [4:0]          sample;
    logic [PW-1:0]       presc_q;
    logic [PW-1:0]       presc_d;
    logic                tick;
    logic [4:0][DW-1:0]  db_cnt_q;
    logic [4:0][DW-1:0]  db_cnt_d;
    logic [4:0]          level_q;
    logic [4:0]          level_d;
    logic [4:0]          rise;
    logic [4:0]          press_q;

    // Two-flop synchroniser; idles high so a released stick matches level 0 after reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q <= 5'b11111;
            sync2_q <= 5'b11111;
        end else begin
            sync1_q <= joy_raw_n;
            sync2_q <= sync1_q;
        end
    end

    assign sample = ~sync2_q;

    // Prescaler: tick is the last cycle of each TICK_DIV-cycle period.
    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Per-bit debounce: any matching cycle restarts the count; only ticks advance it.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        rise     = '0;
        for (int i = 0; i < 5; i++) begin
            if (sample[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (tick) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    level_d[i]  = ~level_q[i];
                    db_cnt_d[i] = '0;
                    rise[i]     = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Prescaler, debounce counters and debounced levels.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            presc_q  <= '0;
            db_cnt_q <= '0;
            level_q  <= '0;
        end else begin
            presc_q  <= presc_d;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

`ifdef JOYSTICK_AUTOREPEAT_EN
    localparam int RP_MAXV = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS
                                                                       : REPEAT_RATE_TICKS;
    localparam int RW = (RP_MAXV > 1) ? $clog2(RP_MAXV) : 1;
    localparam logic [RW-1:0] DELAY_MAX = RW'(REPEAT_DELAY_TICKS - 1);
    localparam logic [RW-1:0] RATE_MAX  = RW'(REPEAT_RATE_TICKS - 1);

    typedef enum logic [1:0] {
        RP_IDLE,
        RP_DELAY,
        RP_REPEAT
    } rp_state_t;

    rp_state_t     rp_state_q [5];
    logic [RW-1:0] rp_cnt_q   [5];

    // Per-bit repeat FSM; press register carries both the debounced rise and repeat pulses.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            press_q <= '0;
            for (int i = 0; i < 5; i++) begin
                rp_state_q[i] <= RP_IDLE;
                rp_cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                press_q[i] <= rise[i];
                case (rp_state_q[i])
                    RP_IDLE: begin
                        if (rise[i]) begin
                            rp_state_q[i] <= RP_DELAY;
                            rp_cnt_q[i]   <= '0;
                        end
                    end
                    RP_DELAY: begin
                        if (!level_q[i]) begin
                            rp_state_q[i] <= RP_IDLE;
                            rp_cnt_q[i]   <= '0;
                        end else if (tick) begin
                            if (rp_cnt_q[i] == DELAY_MAX) begin
                                press_q[i]    <= 1'b1;
                                rp_state_q[i] <= RP_REPEAT;
                                rp_cnt_q[i]   <= '0;
                            end else begin
                                rp_cnt_q[i] <= rp_cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    RP_REPEAT: begin
                        if (!level_q[i]) begin
                            rp_state_q[i] <= RP_IDLE;
                            rp_cnt_q[i]   <= '0;
                        end else if (tick) begin
                            if (rp_cnt_q[i] == RATE_MAX) begin
                                press_q[i]  <= 1'b1;
                                rp_cnt_q[i] <= '0;
                            end else begin
                                rp_cnt_q[i] <= rp_cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        rp_state_q[i] <= RP_IDLE;
                        rp_cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end
`else
    // Press pulse on the debounced 0->1 edge only.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            press_q <= '0;
        end else begin
            press_q <= rise;
        end
    end
`endif

    assign joy_level = level_q;
    assign joy_press = press_q;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Bench for joystick_conditioner with TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2.
// Expected press pulses are queued with their allowed cycle windows and popped as the DUT pulses.
// Outputs are sampled 1 time unit after each rising edge; inputs change right after sampling.
module tb_joystick_conditioner;

    logic       clk_clk     = 1'b0;
    logic       reset_reset = 1'b1;
    logic [4:0] joy_raw_n   = 5'b11111;
    logic [4:0] joy_level;
    logic [4:0] joy_press;

    always #5 clk_clk = ~clk_clk;

    joystick_conditioner #(
        .TICK_DIV          (4),
        .DEBOUNCE_TICKS    (3),
        .REPEAT_DELAY_TICKS(5),
        .REPEAT_RATE_TICKS (2)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .joy_raw_n  (joy_raw_n),
        .joy_level  (joy_level),
        .joy_press  (joy_press)
    );

    typedef struct {
        logic [4:0] mask;
        int         lo;
        int         hi;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic step();
        @(posedge clk_clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        joy_raw_n   = 5'b11111;
        repeat (3) step();
        n_cmp++;
        if (joy_level !== 5'b0 || joy_press !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_held: level=%b press=%b, required 00000/00000", joy_level, joy_press);
        end
        reset_reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            n_cmp++;
            if (joy_level !== 5'b0 || joy_press !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_idle: cycle %0d level=%b press=%b, required 00000/00000", cyc, joy_level, joy_press);
            end
        end
    endtask

    task automatic test_fire();
        int c;
        int rise = -1;
        exp_q.delete();
        joy_raw_n[4] = 1'b0;
        c = cyc;
        exp_q.push_back('{5'b10000, c + 11, c + 15});
        for (int k = 0; k < 25 && !(rise >= 0 && cyc > rise); k++) begin
            step();
            if (joy_press !== 5'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL fire_pulse: unexpected press=%b at cycle %0d, required none", joy_press, cyc - c);
                end else begin
                    e = exp_q.pop_front();
                    if (joy_press !== e.mask || cyc < e.lo || cyc > e.hi) begin
                        n_bad++;
                        $display("FAIL fire_pulse: press=%b at +%0d, required %b within +%0d..+%0d",
                                 joy_press, cyc - c, e.mask, e.lo - c, e.hi - c);
                    end
                end
            end
            if (rise < 0 && joy_level[4]) begin
                rise = cyc;
                n_cmp++;
                if (joy_press !== 5'b10000) begin
                    n_bad++;
                    $display("FAIL fire_pulse_at_rise: press=%b, required 10000", joy_press);
                end
            end
            n_cmp++;
            if (joy_level[3:0] !== 4'b0) begin
                n_bad++;
                $display("FAIL fire_other_bits: level=%b, required 0xxxx bits low", joy_level);
            end
        end
        n_cmp++;
        if (rise < 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL fire_rise: rise seen=%0d pending=%0d, required rise and 0 pending", rise >= 0, exp_q.size());
        end
    endtask

    task automatic test_release();
        int c;
        int fall = -1;
        joy_raw_n[4] = 1'b1;
        c = cyc;
        for (int k = 0; k < 25; k++) begin
            step();
            n_cmp++;
            if (joy_press !== 5'b0) begin
                n_bad++;
                $display("FAIL release_no_pulse: press=%b at +%0d, required 00000", joy_press, cyc - c);
            end
            if (fall < 0 && !joy_level[4]) begin
                fall = cyc;
                n_cmp++;
                if (cyc < c + 11 || cyc > c + 15) begin
                    n_bad++;
                    $display("FAIL release_fall: fell at +%0d, required +11..+15", cyc - c);
                end
            end
        end
        n_cmp++;
        if (fall < 0) begin
            n_bad++;
            $display("FAIL release_fall: level=%b never fell, required bit4 low", joy_level);
        end
    endtask

    task automatic test_glitch();
        int f;
        int rise = -1;
        exp_q.delete();
        joy_raw_n[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 6) joy_raw_n[0] = 1'b1;
            step();
            n_cmp++;
            if (joy_level !== 5'b0 || joy_press !== 5'b0) begin
                n_bad++;
                $display("FAIL glitch_hold: level=%b press=%b, required 00000/00000", joy_level, joy_press);
            end
        end
        joy_raw_n[0] = 1'b0;
        f = cyc;
        exp_q.push_back('{5'b00001, f + 11, f + 15});
        for (int k = 0; k < 25 && !(rise >= 0 && cyc > rise); k++) begin
            step();
            if (joy_press !== 5'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL glitch_pulse: unexpected press=%b at +%0d, required none", joy_press, cyc - f);
                end else begin
                    e = exp_q.pop_front();
                    if (joy_press !== e.mask || cyc < e.lo || cyc > e.hi) begin
                        n_bad++;
                        $display("FAIL glitch_pulse: press=%b at +%0d, required %b within +%0d..+%0d",
                                 joy_press, cyc - f, e.mask, e.lo - f, e.hi - f);
                    end
                end
            end
            if (rise < 0 && joy_level[0]) begin
                rise = cyc;
                n_cmp++;
                if (cyc < f + 11 || cyc > f + 15) begin
                    n_bad++;
                    $display("FAIL glitch_rise: rose at +%0d after final fall, required +11..+15", cyc - f);
                end
            end
        end
        n_cmp++;
        if (rise < 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL glitch_rise: rise seen=%0d pending=%0d, required rise and 0 pending", rise >= 0, exp_q.size());
        end
        joy_raw_n[0] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            step();
            n_cmp++;
            if (joy_press !== 5'b0) begin
                n_bad++;
                $display("FAIL glitch_release: press=%b, required 00000", joy_press);
            end
        end
        n_cmp++;
        if (joy_level !== 5'b0) begin
            n_bad++;
            $display("FAIL glitch_release_level: level=%b, required 00000", joy_level);
        end
    endtask

    task automatic test_hold();
        int c;
        int npulse = 0;
        int fall   = -1;
        logic prev = 1'b0;
        exp_q.delete();
        joy_raw_n[2] = 1'b0;
        c = cyc;
        exp_q.push_back('{5'b00100, c + 11, c + 15});
        for (int k = 0; k < 90; k++) begin
            if (k == 60) joy_raw_n[2] = 1'b1;
            step();
            if (joy_press !== 5'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL hold_pulse: unexpected press=%b at +%0d, required none", joy_press, cyc - c);
                end else begin
                    e = exp_q.pop_front();
                    if (joy_press !== e.mask || cyc < e.lo || cyc > e.hi) begin
                        n_bad++;
                        $display("FAIL hold_pulse: press=%b at +%0d, required %b within +%0d..+%0d",
                                 joy_press, cyc - c, e.mask, e.lo - c, e.hi - c);
                    end
                end
                npulse++;
`ifdef JOYSTICK_AUTOREPEAT_EN
                exp_q.push_back('{5'b00100, cyc + ((npulse == 1) ? 20 : 8), cyc + ((npulse == 1) ? 20 : 8)});
`endif
            end
            if (prev && !joy_level[2]) begin
                fall = cyc;
                n_cmp++;
                if (cyc < c + 71 || cyc > c + 75) begin
                    n_bad++;
                    $display("FAIL hold_fall: fell at +%0d, required +71..+75", cyc - c);
                end
                exp_q.delete();
            end
            prev = joy_level[2];
        end
        n_cmp++;
        if (fall < 0) begin
            n_bad++;
            $display("FAIL hold_fall: level=%b never fell, required bit2 low", joy_level);
        end
        n_cmp++;
`ifdef JOYSTICK_AUTOREPEAT_EN
        if (npulse < 6) begin
            n_bad++;
            $display("FAIL hold_repeat_count: %0d pulses, required at least 6", npulse);
        end
`else
        if (npulse != 1) begin
            n_bad++;
            $display("FAIL hold_single_pulse: %0d pulses, required 1", npulse);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int c;
        int r;
        int npulse = 0;
        int last   = -100;
        int rise   = -1;
        int target;
        bit reached = 1'b0;
`ifdef JOYSTICK_AUTOREPEAT_EN
        target = 2;
`else
        target = 1;
`endif
        exp_q.delete();
        joy_raw_n[1] = 1'b0;
        c = cyc;
        exp_q.push_back('{5'b00010, c + 11, c + 15});
        for (int k = 0; k < 45 && !reached; k++) begin
            step();
            if (joy_press !== 5'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL midrst_pulse: unexpected press=%b at +%0d, required none", joy_press, cyc - c);
                end else begin
                    e = exp_q.pop_front();
                    if (joy_press !== e.mask || cyc < e.lo || cyc > e.hi) begin
                        n_bad++;
                        $display("FAIL midrst_pulse: press=%b at +%0d, required %b within +%0d..+%0d",
                                 joy_press, cyc - c, e.mask, e.lo - c, e.hi - c);
                    end
                end
                npulse++;
                last = cyc;
                exp_q.push_back('{5'b00010, cyc + 20, cyc + 20});
            end
            if (npulse == target && cyc == last + 3) reached = 1'b1;
        end
        n_cmp++;
        if (!reached) begin
            n_bad++;
            $display("FAIL midrst_setup: %0d pulses before budget, required %0d", npulse, target);
        end
        reset_reset = 1'b1;
        step();
        n_cmp++;
        if (joy_level !== 5'b0 || joy_press !== 5'b0) begin
            n_bad++;
            $display("FAIL midrst_outputs: level=%b press=%b, required 00000/00000", joy_level, joy_press);
        end
        reset_reset = 1'b0;
        r = cyc;
        exp_q.delete();
        exp_q.push_back('{5'b00010, r + 11, r + 15});
        for (int k = 0; k < 25 && !(rise >= 0 && cyc > rise); k++) begin
            step();
            if (joy_press !== 5'b0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL midrst_repress: unexpected press=%b at +%0d, required none", joy_press, cyc - r);
                end else begin
                    e = exp_q.pop_front();
                    if (joy_press !== e.mask || cyc < e.lo || cyc > e.hi) begin
                        n_bad++;
                        $display("FAIL midrst_repress: press=%b at +%0d, required %b within +%0d..+%0d",
                                 joy_press, cyc - r, e.mask, e.lo - r, e.hi - r);
                    end
                end
            end
            if (rise < 0 && joy_level[1]) rise = cyc;
        end
        n_cmp++;
        if (rise < 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL midrst_repress: rise seen=%0d pending=%0d, required rise and 0 pending", rise >= 0, exp_q.size());
        end
        joy_raw_n[1] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            step();
            n_cmp++;
            if (joy_press !== 5'b0) begin
                n_bad++;
                $display("FAIL midrst_release: press=%b, required 00000", joy_press);
            end
        end
        n_cmp++;
        if (joy_level !== 5'b0) begin
            n_bad++;
            $display("FAIL midrst_release_level: level=%b, required 00000", joy_level);
        end
    endtask

    initial begin
        test_reset();
        test_fire();
        test_release();
        test_glitch();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/joystick_conditioner.md
# joystick_conditioner

Input conditioning stage between the raw joystick GPIO pins and the Nios system's 5-bit joystick PIO input. Synchronises the five active-low raw switch lines (up, down, left, right, fire), debounces each with a tick-based counter, and presents clean active-high levels to the PIO. It also generates one-cycle press pulses, with optional auto-repeat, for edge-capture logic. Two instances are used: one per stick.

## Interface
- TICK_DIV, 50000: clk_clk cycles per debounce tick (1 ms at 50 MHz); must be ≥ 2.
- DEBOUNCE_TICKS, 5: consecutive mismatching ticks required to change a debounced level; must be ≥ 1.
- REPEAT_DELAY_TICKS, 400: ticks from press pulse to first repeat pulse.
- REPEAT_RATE_TICKS, 100: ticks between subsequent repeat pulses.
- clk_clk  in  1  system clock; single clock domain.
- reset_reset  in  1  synchronous, active-high reset.
- joy_raw_n  in  5  raw pins, active-low, asynchronous; bit 0 up, 1 down, 2 left, 3 right, 4 fire.
- joy_level  out  5  debounced, active-high levels; drives joystick_stick_N_export.
- joy_press  out  5  one-cycle pulse per press event (and per repeat when enabled).

## Operation
- Synchroniser: two flops per bit; sample = ~sync2.
- Prescaler: counter 0..TICK_DIV-1. tick is high for one cycle when the counter equals TICK_DIV-1, then the counter wraps to 0.
- Debounce, per bit, with counter db_cnt:
  - If sample == joy_level[i], db_cnt clears on any cycle (tick or not).
  - If they differ on a tick cycle: if db_cnt == DEBOUNCE_TICKS-1, joy_level[i] toggles and db_cnt clears; otherwise db_cnt increments.
  - If they differ on a non-tick cycle, db_cnt holds.
- Press pulse: joy_press[i] is high for exactly one cycle, registered in the same edge that sets joy_level[i] 0→1. Release (1→0) produces no pulse.
- Bits are fully independent. Simultaneous changes on multiple bits produce simultaneous pulses.
- No mutual exclusion between opposing directions; the Nios software resolves conflicts.
- Auto-repeat, per-bit FSM (only when the macro in Configuration is defined):
  - IDLE: on press pulse → DELAY; rp_cnt = 0.
  - DELAY: rp_cnt increments per tick. At REPEAT_DELAY_TICKS: pulse joy_press[i], go to REPEAT, rp_cnt = 0.
  - REPEAT: rp_cnt increments per tick. At REPEAT_RATE_TICKS: pulse, rp_cnt = 0.
  - DELAY or REPEAT: joy_level[i] == 0 → IDLE in the next cycle; no pulse is issued that cycle.

## Timing
- Reset values:
  - sync flops 1 (idle pin level), so there is no spurious mismatch after reset;
  - joy_level 0, joy_press 0, prescaler 0, all db_cnt/rp_cnt 0, FSMs IDLE.
- Reset asserted mid-debounce or mid-repeat: everything returns to reset values on the next edge; no pulse is emitted.
- Latency, pin change to joy_level:
  - 2 cycles of synchroniser;
  - plus the wait until the DEBOUNCE_TICKS-th tick of continuous mismatch;
  - plus 1 register cycle.
  - Bounds: (DEBOUNCE_TICKS-1)·TICK_DIV+3 to DEBOUNCE_TICKS·TICK_DIV+3 cycles.
- A glitch shorter than one tick period that does not span a tick never changes the level.
- Any sample == level cycle restarts the count.
- Repeat pulses are aligned to the cycle after a tick.
- All pulses are exactly 1 cycle wide. Consecutive pulses on one bit are never closer than TICK_DIV cycles.
- Counter widths are sized with $clog2 of their parameter, with no overflow; the comparison is equality at the limit.

## Configuration
- JOYSTICK_AUTOREPEAT_EN
  - Defined: the per-bit repeat FSM and rp_cnt are present, and joy_press carries initial and repeat pulses.
  - Undefined: no repeat logic is synthesised; joy_press pulses only on the debounced 0→1 edge, and REPEAT_* parameters are ignored.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2.
- Reset release with joy_raw_n=5'b11111, held 100 cycles: joy_level=0 and joy_press=0 for all cycles.
- Drive joy_raw_n[4]=0 and hold: joy_level[4] rises 11–15 cycles later; joy_press[4] is high exactly that one cycle; other bits stay 0.
- Pulse joy_raw_n[0] low for 6 cycles, high for 2, then low again: the level does not rise until 3 uninterrupted ticks after the final fall.
- Release joy_raw_n[4] after debounce: joy_level[4] falls after 3 ticks and no press pulse occurs.
- Macro defined, hold joy_raw_n[2] low for 60 cycles:
  - first pulse at the level rise;
  - second pulse 20 cycles later;
  - further pulses every 8 cycles;
  - pulses stop after the release is debounced.
- Assert reset_reset for 1 cycle mid-repeat: all outputs are 0 on the next edge; with the pin still held low, a fresh debounce produces a new single press pulse.
